// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, opcode classes,
// opcode values (ir[6:2]), immediate-format codes and datapath mux select codes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    CLS_R, CLS_IALU, CLS_LOAD, CLS_STORE, CLS_BRANCH,
    CLS_JALR, CLS_JAL, CLS_AUIPC, CLS_LUI, CLS_ILLEGAL
  } cls_t;

  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_IALU   = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_LUI    = 5'b01101;

  localparam logic [2:0] IMM_I    = 3'd0;
  localparam logic [2:0] IMM_S    = 3'd1;
  localparam logic [2:0] IMM_B    = 3'd2;
  localparam logic [2:0] IMM_U    = 3'd3;
  localparam logic [2:0] IMM_J    = 3'd4;
  localparam logic [2:0] IMM_NONE = 3'd7;

  localparam logic [1:0] PC_SRC_SEQ = 2'd0;
  localparam logic [1:0] PC_SRC_IMM = 2'd1;
  localparam logic [1:0] PC_SRC_ALU = 2'd2;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;
  localparam logic [1:0] WB_SEL_IMM = 3'd3;

  function automatic logic [2:0] imm_of(input cls_t c);
    case (c)
      CLS_IALU, CLS_LOAD, CLS_JALR: imm_of = IMM_I;
      CLS_STORE:                    imm_of = IMM_S;
      CLS_BRANCH:                   imm_of = IMM_B;
      CLS_AUIPC, CLS_LUI:           imm_of = IMM_U;
      CLS_JAL:                      imm_of = IMM_J;
      default:                      imm_of = IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_opcode_class.sv
// Combinational opcode classifier: ir[6:0] -> class, with illegal flag for
// non-32-bit encodings (ir[1:0] != 2'b11) and unlisted opcodes.
module opcode_class
  import ctrl_pkg::*;
(
  input  logic [6:0] opc,
  output cls_t       cls,
  output logic       illegal
);

  always_comb begin
    cls = CLS_ILLEGAL;
    if (opc[1:0] == 2'b11) begin
      case (opc[6:2])
        OP_R:      cls = CLS_R;
        OP_IALU:   cls = CLS_IALU;
        OP_LOAD:   cls = CLS_LOAD;
        OP_STORE:  cls = CLS_STORE;
        OP_BRANCH: cls = CLS_BRANCH;
        OP_JALR:   cls = CLS_JALR;
        OP_JAL:    cls = CLS_JAL;
        OP_AUIPC:  cls = CLS_AUIPC;
        OP_LUI:    cls = CLS_LUI;
        default:   cls = CLS_ILLEGAL;
      endcase
    end
    illegal = (cls == CLS_ILLEGAL);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM with memory watchdog and instret counter; 3-5 cycles
// per instruction plus memory wait states, mem_req held until mem_ready.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ir,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             alu_a_sel,
  output logic             alu_b_sel,
  output logic [2:0]       imm_type,
  output logic             trap,
  output logic [CNT_W-1:0] instret
);

  localparam int WD_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_TIMEOUT - 1);

  state_t          state;
  cls_t            cls;
  logic            illegal;
  logic [WD_W-1:0] wdog;
  logic            retire;
  logic            unused_ir_hi;

  assign unused_ir_hi = ^ir[31:7];

  opcode_class u_opcode_class (
    .opc     (ir[6:0]),
    .cls     (cls),
    .illegal (illegal)
  );

  // Outputs decode from the state register and opcode class; only ir_we and the
  // retiring pc_we/pc_src look at mem_ready / branch_taken.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_SRC_SEQ;
    rf_we     = 1'b0;
    wb_sel    = WB_SEL_ALU;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    imm_type  = IMM_NONE;
    retire    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
      end
      S_DECODE: imm_type = imm_of(cls);
      S_EXEC: begin
        imm_type  = imm_of(cls);
        alu_a_sel = (cls == CLS_AUIPC);
        alu_b_sel = !(cls == CLS_R || cls == CLS_BRANCH);
        if (cls == CLS_BRANCH) begin
          pc_we  = 1'b1;
          pc_src = branch_taken ? PC_SRC_IMM : PC_SRC_SEQ;
          retire = 1'b1;
        end
      end
      S_MEM: begin
        imm_type = imm_of(cls);
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (cls == CLS_STORE);
        if (cls == CLS_STORE && mem_ready) begin
          pc_we  = 1'b1;
          retire = 1'b1;
        end
      end
      S_WB: begin
        imm_type = imm_of(cls);
        rf_we    = 1'b1;
        pc_we    = 1'b1;
        retire   = 1'b1;
        case (cls)
          CLS_LOAD:          wb_sel = WB_SEL_MEM;
          CLS_JAL, CLS_JALR: wb_sel = WB_SEL_PC4;
          CLS_LUI:           wb_sel = WB_SEL_IMM;
          default:           wb_sel = WB_SEL_ALU;
        endcase
        if (cls == CLS_JAL)       pc_src = PC_SRC_IMM;
        else if (cls == CLS_JALR) pc_src = PC_SRC_ALU;
      end
      default: ;
    endcase
  end

  assign trap = (state == S_TRAP);

  // wdog is only non-zero inside FETCH/MEM, so clearing it everywhere else and on
  // every completed handshake equals clearing it on entry to FETCH or MEM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      wdog    <= '0;
      instret <= '0;
    end else begin
      if (retire) instret <= instret + CNT_W'(1);
      case (state)
        S_IDLE: begin
          state <= S_FETCH;
          wdog  <= '0;
        end
        S_FETCH, S_MEM: begin
          if (mem_ready) begin
            wdog <= '0;
            if (state == S_FETCH)     state <= S_DECODE;
            else if (cls == CLS_LOAD) state <= S_WB;
            else                      state <= S_FETCH;
          end else if (wdog == WD_LAST) begin
            state <= S_TRAP;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        S_DECODE: begin
          state <= illegal ? S_TRAP : S_EXEC;
          wdog  <= '0;
        end
        S_EXEC: begin
          wdog <= '0;
          if (cls == CLS_BRANCH)                         state <= S_FETCH;
          else if (cls == CLS_LOAD || cls == CLS_STORE) state <= S_MEM;
          else                                           state <= S_WB;
        end
        S_WB: begin
          state <= S_FETCH;
          wdog  <= '0;
        end
        default: begin
          state <= S_TRAP;
          wdog  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed boundary cases, then a random instruction stream
// scored against a per-instruction reference model through handshake/retire queues.
module tb_multicycle_ctrl;

  localparam int NRAND = 300;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ir;
  logic        branch_taken;
  logic        mem_ready;
  logic        mem_req, mem_we, addr_sel, ir_we, pc_we, rf_we, alu_a_sel, alu_b_sel, trap;
  logic [1:0]  pc_src, wb_sel;
  logic [2:0]  imm_type;
  logic [31:0] instret;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .ir(ir), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .rf_we(rf_we), .wb_sel(wb_sel), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .imm_type(imm_type), .trap(trap), .instret(instret)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Expected retirement record for one instruction.
  typedef struct packed {
    logic [1:0]  pc_src;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        wb_chk;
    logic [2:0]  imm;
    logic [31:0] cnt;
  } ret_t;

  ret_t       ret_q[$];
  logic [1:0] hs_q[$];
  bit         mon_en = 1'b0;
  int         ret_seen = 0;

  // Opcode table: R, I-ALU, LOAD, STORE, BRANCH, JALR, JAL, AUIPC, LUI
  logic [4:0] ops[9] = '{5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000,
                         5'b11001, 5'b11011, 5'b00101, 5'b01101};

  function automatic ret_t model(input int k, input bit bt, input int n);
    ret_t r;
    r.cnt = n; r.rf_we = 1'b1; r.wb_chk = 1'b1; r.pc_src = 2'd0; r.wb_sel = 2'd0; r.imm = 3'd7;
    case (k)
      0: r.imm = 3'd7;
      1: r.imm = 3'd0;
      2: begin r.imm = 3'd0; r.wb_sel = 2'd1; end
      3: begin r.imm = 3'd1; r.rf_we = 1'b0; r.wb_chk = 1'b0; end
      4: begin r.imm = 3'd2; r.rf_we = 1'b0; r.wb_chk = 1'b0; r.pc_src = {1'b0, bt}; end
      5: begin r.imm = 3'd0; r.wb_sel = 2'd2; r.pc_src = 2'd2; end
      6: begin r.imm = 3'd4; r.wb_sel = 2'd2; r.pc_src = 2'd1; end
      7: r.imm = 3'd3;
      default: begin r.imm = 3'd3; r.wb_sel = 2'd3; end
    endcase
    return r;
  endfunction

  // Monitor: pops expectations on every memory handshake and every retiring pc_we.
  logic       pend;
  logic [1:0] pend_aw;
  always @(negedge clk) begin
    if (!mon_en) begin
      pend = 1'b0;
    end else begin
      #2;
      if (pend) chk("req_held_stable", {mem_req, addr_sel, mem_we}, {1'b1, pend_aw});
      chk("rf_we_without_pc_we", rf_we & ~pc_we, 0);
      chk("no_trap_random", trap, 0);
      if (mem_req && mem_ready) begin
        chk("hs_expected", hs_q.size() != 0, 1);
        if (hs_q.size() != 0) chk("hs_addr_we", {addr_sel, mem_we}, hs_q.pop_front());
      end
      if (pc_we) begin
        chk("ret_expected", ret_q.size() != 0, 1);
        if (ret_q.size() != 0) begin
          ret_t e;
          e = ret_q.pop_front();
          chk("ret_pc_src", pc_src, e.pc_src);
          chk("ret_rf_we", rf_we, e.rf_we);
          if (e.wb_chk) chk("ret_wb_sel", wb_sel, e.wb_sel);
          chk("ret_imm_type", imm_type, e.imm);
          chk("ret_instret", instret, e.cnt);
        end
        ret_seen++;
      end
      pend    = mem_req && !mem_ready;
      pend_aw = {addr_sel, mem_we};
    end
  end

  int n_issue;

  task automatic issue;
    int  k;
    bit  bt;
    k  = $urandom_range(0, 8);
    bt = 1'($urandom_range(0, 1));
    ir = {25'($urandom), ops[k], 2'b11};
    branch_taken = bt;
    ret_q.push_back(model(k, bt, n_issue));
    if (k == 2) hs_q.push_back(2'b10);
    if (k == 3) hs_q.push_back(2'b11);
    hs_q.push_back(2'b00);
    n_issue++;
  endtask

  initial begin
    int n, lat, cyc, wait_left;
    logic ld;

    rst = 1'b1; ir = 32'h00500093; mem_ready = 1'b0; branch_taken = 1'b0;
    tick; tick;
    chk("reset_outputs", {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, rf_we, wb_sel,
                          alu_a_sel, alu_b_sel, trap}, 0);
    chk("reset_imm_type", imm_type, 3'd7);
    chk("reset_instret", instret, 0);

    // ADDI with immediate mem_ready: retire on the 4th cycle counting FETCH
    rst = 1'b0; tick;
    mem_ready = 1'b1; #1;
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      if (pc_we) begin lat = i; break; end
      tick;
    end
    chk("addi_latency", lat, 3);
    chk("addi_wb", {rf_we, wb_sel, pc_src, imm_type}, {1'b1, 2'd0, 2'd0, 3'd0});
    mem_ready = 1'b0; tick;
    chk("addi_instret", instret, 1);

    // LW with 3 wait cycles in MEM
    ir = 32'h0000A103; mem_ready = 1'b1; #1;
    chk("lw_fetch_ir_we", ir_we, 1);
    tick; mem_ready = 1'b0;
    tick; tick;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      #1;
      if ({mem_req, addr_sel, mem_we} == 3'b110) n++;
      tick;
    end
    chk("lw_mem_hold_cycles", n, 4);
    mem_ready = 1'b0; #1;
    chk("lw_wb", {pc_we, rf_we, wb_sel, trap, imm_type}, {1'b1, 1'b1, 2'd1, 1'b0, 3'd0});
    tick;
    chk("lw_instret", instret, 2);

    // Watchdog: fetch never answered
    n = 0;
    for (int i = 0; i < 40 && !trap; i++) begin
      if (mem_req) n++;
      tick;
    end
    chk("wdog_req_cycles", n, 16);
    chk("trap_flag", trap, 1);
    chk("trap_enables", {mem_req, ir_we, pc_we, rf_we, mem_we}, 0);
    chk("trap_imm_type", imm_type, 3'd7);
    mem_ready = 1'b1; tick; tick;
    chk("trap_sticky", trap, 1);
    mem_ready = 1'b0;
    rst = 1'b1; tick;
    chk("post_trap_reset", {trap, mem_req}, 0);
    chk("post_trap_instret", instret, 0);

    // mem_ready on the last allowed cycle wins over the watchdog
    rst = 1'b0; ir = 32'h00500093; tick;
    for (int i = 0; i < 15; i++) tick;
    mem_ready = 1'b1; #1;
    chk("wdog_edge_ir_we", {trap, ir_we}, 2'b01);
    tick; mem_ready = 1'b0;
    chk("wdog_edge_no_trap", {trap, mem_req}, 0);
    tick; tick;
    chk("wdog_edge_retire", {pc_we, rf_we}, 2'b11);
    tick;

    // Illegal encodings trap the cycle after DECODE
    for (int k = 0; k < 2; k++) begin
      ir = (k == 0) ? 32'h0000007F : 32'h00500091;
      mem_ready = 1'b1; tick; mem_ready = 1'b0;
      chk("illegal_decode_no_trap", trap, 0);
      tick;
      chk("illegal_trap", {trap, mem_req, pc_we, rf_we}, 4'b1000);
      rst = 1'b1; tick; rst = 1'b0; tick;
    end

    // Reset in the middle of a MEM request
    ir = 32'h0000A103; mem_ready = 1'b1; tick; mem_ready = 1'b0; tick; tick;
    chk("mem_before_rst", {mem_req, addr_sel}, 2'b11);
    rst = 1'b1; tick;
    chk("rst_drops_req", {mem_req, imm_type}, {1'b0, 3'd7});
    rst = 1'b0; tick;
    chk("fetch_after_rst", {mem_req, addr_sel, mem_we}, 3'b100);

    // Random instruction stream with random memory latency
    rst = 1'b1; tick;
    hs_q.delete(); ret_q.delete();
    hs_q.push_back(2'b00);
    n_issue = 0; wait_left = 0; cyc = 0;
    mon_en = 1'b1; rst = 1'b0;
    while (ret_seen < NRAND && cyc < 20000) begin
      @(negedge clk);
      if (mem_req) begin
        if (wait_left == 0) begin
          mem_ready = 1'b1;
          wait_left = $urandom_range(0, 3);
        end else begin
          mem_ready = 1'b0;
          wait_left--;
        end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      #1 ld = ir_we;
      @(posedge clk); #1;
      if (ld) issue();
      cyc++;
    end
    @(negedge clk); #3;
    mon_en = 1'b0;
    chk("random_all_retired", ret_seen >= NRAND, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
